// File: rtl/traffic_timer_ctrl_if.sv
// Threshold configuration bus for traffic_timer_ctrl: write strobe, select, data
// and a one-cycle accept pulse.
interface traffic_timer_ctrl_if;
    logic       cfg_we;
    logic       cfg_sel;
    logic [7:0] cfg_data;
    logic       cfg_ack;

    modport master (output cfg_we, cfg_sel, cfg_data, input cfg_ack);
    modport slave  (input cfg_we, cfg_sel, cfg_data, output cfg_ack);
endinterface

// File: rtl/traffic_timer_ctrl.sv
// Interval timer for a traffic-light FSM: long/short expiry flags, shadowed thresholds
// and a debounced side-road car sensor. Define TIMER_CAR_LATCH_EN to latch c until ST.
module traffic_timer_ctrl #(
    parameter int LONG_DEFAULT  = 60,
    parameter int SHORT_DEFAULT = 5,
    parameter int DEB_CYCLES    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ST,
    input  logic                 car_raw,
    traffic_timer_ctrl_if.slave  cfg,
    output logic                 TL,
    output logic                 TS,
    output logic                 c,
    output logic [7:0]           count
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] LONG_RST  = 8'(LONG_DEFAULT);
    localparam logic [7:0] SHORT_RST = 8'(SHORT_DEFAULT);
    localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);

    state_t     state, state_nx;
    logic [7:0] count_nx;
    logic [7:0] sh_long, sh_short, sh_long_nx, sh_short_nx;
    logic [7:0] act_long, act_short, act_long_nx, act_short_nx;
    logic [7:0] wr_val;
    logic       ts_nx, tl_nx, ack_nx;
    logic [3:0] deb_cnt, deb_cnt_nx;
    logic       deb_lvl, deb_lvl_nx;

    // A zero threshold would make the flag fire in the ST cycle itself, so clamp to 1.
    assign wr_val = (cfg.cfg_data == 8'd0) ? 8'd1 : cfg.cfg_data;

    always_comb begin
        state_nx     = state;
        count_nx     = count;
        sh_long_nx   = sh_long;
        sh_short_nx  = sh_short;
        act_long_nx  = act_long;
        act_short_nx = act_short;
        ack_nx       = cfg.cfg_we;

        if (cfg.cfg_we) begin
            if (cfg.cfg_sel) sh_short_nx = wr_val;
            else             sh_long_nx  = wr_val;
        end

        // ST samples the post-write shadows so a same-cycle write takes effect now.
        if (ST) begin
            state_nx     = RUN;
            count_nx     = 8'd0;
            act_long_nx  = sh_long_nx;
            act_short_nx = sh_short_nx;
        end else if (state == RUN && count != 8'hFF) begin
            count_nx = count + 8'd1;
        end

        ts_nx = (state_nx == RUN) && (count_nx >= act_short_nx);
        tl_nx = (state_nx == RUN) && (count_nx >= act_long_nx);

        deb_lvl_nx = deb_lvl;
        deb_cnt_nx = 4'd0;
        if (car_raw != deb_lvl) begin
            if (deb_cnt == DEB_LAST) deb_lvl_nx = car_raw;
            else                     deb_cnt_nx = deb_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 8'd0;
            TS          <= 1'b0;
            TL          <= 1'b0;
            cfg.cfg_ack <= 1'b0;
            sh_long     <= LONG_RST;
            sh_short    <= SHORT_RST;
            act_long    <= LONG_RST;
            act_short   <= SHORT_RST;
            deb_cnt     <= 4'd0;
            deb_lvl     <= 1'b0;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            TS          <= ts_nx;
            TL          <= tl_nx;
            cfg.cfg_ack <= ack_nx;
            sh_long     <= sh_long_nx;
            sh_short    <= sh_short_nx;
            act_long    <= act_long_nx;
            act_short   <= act_short_nx;
            deb_cnt     <= deb_cnt_nx;
            deb_lvl     <= deb_lvl_nx;
        end
    end

`ifdef TIMER_CAR_LATCH_EN
    logic c_lat, c_lat_nx;

    always_comb begin
        c_lat_nx = c_lat;
        if (ST)                       c_lat_nx = 1'b0;
        else if (deb_lvl_nx && !deb_lvl) c_lat_nx = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) c_lat <= 1'b0;
        else       c_lat <= c_lat_nx;
    end

    assign c = c_lat;
`else
    assign c = deb_lvl;
`endif
endmodule

// File: tb/tb_traffic_timer_ctrl.sv
// Self-checking bench for traffic_timer_ctrl: vector table, directed corner sequences,
// then randomized traffic against a run-length/elapsed-time reference model.
module tb_traffic_timer_ctrl;
    localparam int LONG_D  = 60;
    localparam int SHORT_D = 5;
    localparam int DEB     = 3;

    logic       clk = 1'b0;
    logic       reset, ST, car_raw;
    logic       TL, TS, c;
    logic [7:0] count;

    traffic_timer_ctrl_if cfg();

    traffic_timer_ctrl #(.LONG_DEFAULT(LONG_D), .SHORT_DEFAULT(SHORT_D), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .ST(ST), .car_raw(car_raw), .cfg(cfg),
        .TL(TL), .TS(TS), .c(c), .count(count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic cycle(input logic r, input logic st, input logic car,
                         input logic we, input logic sel, input logic [7:0] d);
        reset = r; ST = st; car_raw = car;
        cfg.cfg_we = we; cfg.cfg_sel = sel; cfg.cfg_data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    typedef struct {
        logic       r, st, we, sel;
        logic [7:0] d;
        int         e_cnt;
        logic       e_ts, e_tl, e_ack;
    } vec_t;
    vec_t tbl[$];

    // Reference model: elapsed cycles since ST (unbounded, clipped on read) and
    // run length of identical raw sensor samples.
    int  m_el, m_shl, m_shs, m_al, m_as, m_rl;
    bit  m_run, m_ack, m_deb, m_last, m_lat;

    task automatic model_step(input bit r, input bit st, input bit car,
                              input bit we, input bit sel, input int d);
        bit old_deb;
        if (r) begin
            m_run = 0; m_el = 0; m_shl = LONG_D; m_shs = SHORT_D; m_al = LONG_D; m_as = SHORT_D;
            m_ack = 0; m_deb = 0; m_last = 0; m_rl = 0; m_lat = 0;
            return;
        end
        m_ack = we;
        if (we) begin
            if (sel) m_shs = (d == 0) ? 1 : d;
            else     m_shl = (d == 0) ? 1 : d;
        end
        if (st) begin m_run = 1; m_el = 0; m_al = m_shl; m_as = m_shs; end
        else if (m_run) m_el++;
        if (car == m_last) m_rl++;
        else begin m_rl = 1; m_last = car; end
        old_deb = m_deb;
        if (car != m_deb && m_rl >= DEB) m_deb = car;
        if (st) m_lat = 0;
        else if (m_deb && !old_deb) m_lat = 1;
    endtask

    function automatic int clip(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic bit exp_c();
`ifdef TIMER_CAR_LATCH_EN
        return m_lat;
`else
        return m_deb;
`endif
    endfunction

    initial begin
        int  e;
        bit  car_v;
        bit  rr, rs, rw, rsel;
        int  rd;

        reset = 1'b1; ST = 1'b0; car_raw = 1'b0;
        cfg.cfg_we = 1'b0; cfg.cfg_sel = 1'b0; cfg.cfg_data = 8'd0;

        //            r  st we sel d    cnt ts tl ack
        tbl.push_back('{1, 0, 0, 0, 8'd0,  0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 8'd7,  0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 8'd0,  0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  1, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 8'd5,  2, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  3, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 8'd0,  0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  2, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  3, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  4, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  5, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 8'd2,  6, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 8'd0,  0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 8'd0,  2, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 8'd60, 3, 0, 1, 1});
        tbl.push_back('{1, 0, 0, 0, 8'd0,  0, 0, 0, 0});

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].st, 1'b0, tbl[i].we, tbl[i].sel, tbl[i].d);
            chk($sformatf("tbl%0d_cnt", i), count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_ts", i), TS, tbl[i].e_ts);
            chk($sformatf("tbl%0d_tl", i), TL, tbl[i].e_tl);
            chk($sformatf("tbl%0d_ack", i), cfg.cfg_ack, tbl[i].e_ack);
        end

        // Basic interval with defaults, including saturation.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        chk("a_cnt0", count, 0);
        chk("a_ts0", TS, 0);
        for (int k = 1; k <= 300; k++) begin
            idle(1);
            e = clip(k);
            chk("a_cnt", count, e);
            chk("a_ts", TS, (e >= SHORT_D) ? 1 : 0);
            chk("a_tl", TL, (e >= LONG_D) ? 1 : 0);
        end

        // Retrigger at count 30.
        cycle(0, 1, 0, 0, 0, 0);
        idle(30);
        chk("b_cnt30", count, 30);
        chk("b_ts30", TS, 1);
        cycle(0, 1, 0, 0, 0, 0);
        chk("b_cnt_rst", count, 0);
        chk("b_ts_rst", TS, 0);
        chk("b_tl_rst", TL, 0);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            chk("b_ts", TS, (k >= 5) ? 1 : 0);
        end

        // Short-threshold write mid-run applies only from the next ST.
        cycle(0, 1, 0, 0, 0, 0);
        idle(2);
        chk("c_cnt2", count, 2);
        cycle(0, 0, 0, 1, 1, 8'd10);
        chk("c_ack", cfg.cfg_ack, 1);
        idle(1);
        chk("c_ack_drop", cfg.cfg_ack, 0);
        chk("c_ts4", TS, 0);
        idle(1);
        chk("c_ts5", TS, 1);
        cycle(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            chk("c_ts_new", TS, (k >= 10) ? 1 : 0);
        end

        // Zero long threshold with ST in the same cycle; then reset beats a write.
        cycle(0, 1, 0, 1, 0, 8'd0);
        chk("d_tl0", TL, 0);
        idle(1);
        chk("d_tl1", TL, 1);
        cycle(1, 0, 0, 1, 1, 8'd20);
        chk("d_rst_ack", cfg.cfg_ack, 0);
        idle(1);
        chk("d_rst_ack2", cfg.cfg_ack, 0);
        chk("d_idle_cnt", count, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= LONG_D; k++) begin
            idle(1);
            chk("d_ts_dflt", TS, (k >= SHORT_D) ? 1 : 0);
            chk("d_tl_dflt", TL, (k >= LONG_D) ? 1 : 0);
        end

        // Debounce and latch behaviour.
        cycle(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 1, 0, 0, 0);
            chk("e_glitch_hi", c, 0);
        end
        cycle(0, 0, 0, 0, 0, 0);
        chk("e_back_lo", c, 0);
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 1, 0, 0, 0);
            chk("e_rise", c, (k == 3) ? 1 : 0);
        end
        cycle(0, 0, 0, 0, 0, 0);
        chk("e_glitch_lo", c, 1);
        cycle(0, 0, 1, 0, 0, 0);
        chk("e_hold_hi", c, 1);
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 0, 0, 0, 0, 0);
`ifdef TIMER_CAR_LATCH_EN
            chk("e_latched", c, 1);
`else
            chk("e_fall", c, (k >= 3) ? 0 : 1);
`endif
        end
        cycle(0, 1, 0, 0, 0, 0);
        chk("e_st_clr", c, 0);

        // Randomized traffic against the reference model.
        car_v = 0;
        cycle(1, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            rr    = ($urandom_range(0, 99) == 0);
            rs    = ($urandom_range(0, 39) == 0);
            rw    = ($urandom_range(0, 7) == 0);
            rsel  = $urandom_range(0, 1);
            rd    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 80);
            if ($urandom_range(0, 3) == 0) car_v = ~car_v;
            cycle(rr, rs, car_v, rw, rsel, 8'(rd));
            model_step(rr, rs, car_v, rw, rsel, rd);
            e = clip(m_el);
            chk("r_cnt", count, e);
            chk("r_ts", TS, (m_run && e >= m_as) ? 1 : 0);
            chk("r_tl", TL, (m_run && e >= m_al) ? 1 : 0);
            chk("r_ack", cfg.cfg_ack, m_ack);
            chk("r_c", c, exp_c());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/traffic_timer_ctrl.md
TRAFFIC_TIMER_CTRL -- requirements
Module: traffic_timer_ctrl

Interface
REQ-001 SHALL have parameter LONG_DEFAULT, default 60: reset value of the long threshold, in clk cycles.
REQ-002 SHALL have parameter SHORT_DEFAULT, default 5: reset value of the short threshold, in clk cycles.
REQ-003 SHALL have parameter DEB_CYCLES, default 3: debounce length for the car sensor; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ST, input, 1 bit: start-timer pulse from the traffic-light FSM.
REQ-007 SHALL have port car_raw, input, 1 bit: raw side-road car sensor, already synchronous to clk.
REQ-008 SHALL have port cfg_we, input, 1 bit: threshold write strobe.
REQ-009 SHALL have port cfg_sel, input, 1 bit: threshold select; 0 = long, 1 = short.
REQ-010 SHALL have port cfg_data, input, 8 bits: threshold value to write.
REQ-011 SHALL have port cfg_ack, output, 1 bit: write-accepted pulse.
REQ-012 SHALL have port TL, output, 1 bit: long interval expired.
REQ-013 SHALL have port TS, output, 1 bit: short interval expired.
REQ-014 SHALL have port c, output, 1 bit: debounced car-present indication.
REQ-015 SHALL have port count, output, 8 bits: current timer count.

Function
REQ-016 SHALL implement a two-state machine with states IDLE and RUN.
REQ-017 SHALL, on ST=1 in either state, clear count to 0, enter RUN, and load the active thresholds from the shadow thresholds in the same cycle.
REQ-018 SHALL, in RUN with ST=0, increment count by 1 each cycle and saturate at 255 with no wrap.
REQ-019 SHALL hold count while in IDLE.
REQ-020 SHALL drive TS = (state==RUN) && (count >= active_short) and TL = (state==RUN) && (count >= active_long), registered; both 0 in IDLE and both 0 in the cycle after ST.
REQ-021 SHALL keep TS and TL asserted once set until the next ST; a retrigger ST clears both on the following cycle.
REQ-022 SHALL, on cfg_we=1, write cfg_data into the shadow threshold chosen by cfg_sel, and SHALL force a written value of 0 to 1.
REQ-023 SHALL pulse cfg_ack high for exactly one cycle, in the cycle after each cfg_we; back-to-back writes give back-to-back acks.
REQ-024 SHALL leave the active thresholds of a running interval unaffected by shadow writes; the new values apply from the next ST.
REQ-025 SHALL, when cfg_we and ST occur in the same cycle, use the newly written value in the run that ST starts.
REQ-026 SHALL raise the debounced level after car_raw has been 1 for DEB_CYCLES consecutive cycles, and clear it after car_raw has been 0 for DEB_CYCLES consecutive cycles; any shorter glitch SHALL leave it unchanged.

Reset
REQ-027 SHALL, on reset=1 at a clk edge, set state=IDLE, count=0, TS=0, TL=0, c=0, cfg_ack=0, and clear the debounce counter.
REQ-028 SHALL reset the shadow and active thresholds to LONG_DEFAULT and SHORT_DEFAULT.
REQ-029 SHALL give reset priority over ST and cfg_we in the same cycle, discarding the write with no ack.
REQ-030 SHALL, when reset is asserted mid-RUN, abort the interval; a new interval starts only on a later ST.

Configuration
REQ-031 SHALL, with macro TIMER_CAR_LATCH_EN defined, latch c at 1 once the debounced level rises, and clear it only on ST or reset.
REQ-032 SHALL, without TIMER_CAR_LATCH_EN, drive c equal to the debounced level.

Verification
REQ-033 SHALL cover a basic interval with default thresholds: reset, then ST pulse -> TS rises when count reaches 5, TL rises when count reaches 60, count stops at 255.
REQ-034 SHALL cover retrigger: ST again at count=30 -> TS and TL low in the next cycle, count restarts at 0, TS rises again at count 5.
REQ-035 SHALL cover a write during RUN: cfg_sel=1, cfg_data=10 at count 2 -> cfg_ack one cycle later, TS still at count 5 in this run and at count 10 after the next ST.
REQ-036 SHALL cover the write boundaries: cfg_data=0 with cfg_sel=0 and ST in the same cycle -> long threshold is 1, TL rises at count 1; simultaneous reset and cfg_we -> no ack, defaults kept.
REQ-037 SHALL cover debounce with DEB_CYCLES=3: car_raw high for 2 cycles -> c stays 0; high for 3 cycles -> c=1; a low pulse of 1 cycle -> c remains 1.
REQ-038 SHALL cover the latch option: with TIMER_CAR_LATCH_EN defined, car_raw drops for 5 cycles -> c stays 1 until ST; without the macro, c drops after 3 cycles.
